dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 128-word data RAM. It shares the RAM between the CPU data port (M0) and the debug/loader port (M1), which the memory IO bus decode feeds. Each request is latched, driven to the RAM for one cycle, and completed with a one-cycle ack carrying read data. Arbitration is round-robin when both requesters contend.

---
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer that shares one
// single-port data RAM between the CPU and debug/loader ports.
module dmem_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_wait,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_wait,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_we,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            cur_q, cur_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            win;

  // State, grant history and latched RAM command
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Arbitrate in IDLE, strobe the RAM in ISSUE, ack in RESP
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // on contention the port not served last goes next
          win     = (m0_req && m1_req) ? ~last_q : m1_req;
          state_d = ISSUE;
          cur_d   = win;
          last_d  = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;

  assign m0_ack   = (state_q == RESP) && !cur_q;
  assign m1_ack   = (state_q == RESP) &&  cur_q;
  assign m0_wait  = m0_req && !m0_ack;
  assign m1_wait  = m1_req && !m1_ack;
  assign m0_rdata = ram_data_out;
  assign m1_rdata = ram_data_out;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a RAM model
// and a cycle-number transaction model of the expected outputs.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_ack, m0_wait, m1_ack, m1_wait;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;
  logic [DW-1:0] ram_data_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m0_wait(m0_wait),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .m1_wait(m1_wait),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_we(ram_we), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read single-port RAM
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  // transaction model: grant at cycle g, RAM strobe g+1, ack g+2,
  // next grant possible at g+3
  int            g = -100;
  logic          last = 1'b1;
  logic          own = 1'b0;
  logic          twe = 1'b0;
  logic [AW-1:0] taddr = '0;
  logic [DW-1:0] twd = '0;
  logic [DW-1:0] shadow [0:127];
  logic          m_win;
  assign m_win = (m0_req && m1_req) ? !last : m1_req;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g    <= -100;
      last <= 1'b1;
    end else begin
      if (cyc == g + 1 && twe) shadow[taddr] <= twd;
      if (cyc >= g + 3 && (m0_req || m1_req)) begin
        g     <= cyc;
        own   <= m_win;
        last  <= m_win;
        twe   <= m_win ? m1_we : m0_we;
        taddr <= m_win ? m1_addr : m0_addr;
        twd   <= m_win ? m1_wdata : m0_wdata;
      end
    end
  end

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rstn) begin
      chkb("ack0", m0_ack, (cyc == g + 2) && !own);
      chkb("ack1", m1_ack, (cyc == g + 2) && own);
      chkb("ram_we", ram_we, (cyc == g + 1) && twe);
      chkb("wait0", m0_wait, m0_req && !((cyc == g + 2) && !own));
      chkb("wait1", m1_wait, m1_req && !((cyc == g + 2) && own));
      chkw("rd0_pass", m0_rdata, ram_data_out);
      chkw("rd1_pass", m1_rdata, ram_data_out);
      if (cyc == g + 1) begin
        chkw("ram_addr", 32'(ram_addr), 32'(taddr));
        if (twe) chkw("ram_din", ram_data_in, twd);
      end
      if (cyc == g + 2 && !twe)
        chkw("rdata", own ? m1_rdata : m0_rdata, shadow[taddr]);
    end
  end

  int n_ack0 = 0;
  int we_cnt = 0;
  always @(negedge clk) begin
    if (m0_ack) n_ack0 <= n_ack0 + 1;
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // issue one request and hold it until acked; drop req in the ack cycle
  task automatic do_txn(input int m, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int ac, output logic [DW-1:0] rd,
                        output int nw);
    bit done = 1'b0;
    ac = -1;
    rd = '0;
    nw = 0;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (m == 0 ? m0_ack : m1_ack) begin
        ac = cyc;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        done = 1'b1;
      end else if (m == 0 ? m0_wait : m1_wait) begin
        nw++;
      end
    end
    #1;
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: port %0d got no ack want ack", m);
    end
  endtask

  int            s, k, w;
  int            a0, a1, b0, b1;
  int            nw0, nw1, nw2, nw3;
  logic [DW-1:0] r0, r1, r2, r3;

  initial begin
    // reset held with both ports requesting
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 7'h01;
    m0_wdata = 32'hA0A0_0001;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 7'h02;
    m1_wdata = 32'hB0B0_0002;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkb("rst_we", ram_we, 1'b0);
    chkb("rst_ack0", m0_ack, 1'b0);
    chkb("rst_ack1", m1_ack, 1'b0);
    chkw("rst_addr", 32'(ram_addr), 32'h0);
    chkw("rst_din", ram_data_in, 32'h0);
    step();
    rstn = 1'b1;
    s = cyc;
    fork
      do_txn(0, 1'b1, 7'h01, 32'hA0A0_0001, a0, r0, nw0);
      do_txn(1, 1'b1, 7'h02, 32'hB0B0_0002, a1, r1, nw1);
    join
    chkw("t1_ack0_cyc", a0, s + 2);
    chkw("t1_ack1_cyc", a1, s + 5);

    // M0 write then read back
    step();
    w = we_cnt;
    s = cyc;
    do_txn(0, 1'b1, 7'h05, 32'hDEAD_BEEF, a0, r0, nw0);
    chkw("t2_wack_cyc", a0, s + 2);
    chkw("t2_we_pulses", we_cnt - w, 1);
    step();
    s = cyc;
    do_txn(0, 1'b0, 7'h05, 32'h0, a0, r0, nw0);
    chkw("t2_rack_cyc", a0, s + 2);
    chkw("t2_rdata", r0, 32'hDEAD_BEEF);

    // continuous contention after a fresh reset
    apply_reset();
    s = cyc;
    fork
      begin
        do_txn(0, 1'b1, 7'h20, 32'hC0FF_EE01, a0, r0, nw0);
        do_txn(0, 1'b0, 7'h20, 32'h0, a1, r2, nw2);
      end
      begin
        do_txn(1, 1'b1, 7'h30, 32'h5EED_0002, b0, r1, nw1);
        do_txn(1, 1'b0, 7'h30, 32'h0, b1, r3, nw3);
      end
    join
    chkw("t3_m0a_cyc", a0, s + 2);
    chkw("t3_m1a_cyc", b0, s + 5);
    chkw("t3_m0b_cyc", a1, s + 8);
    chkw("t3_m1b_cyc", b1, s + 11);
    chkw("t3_m1_waits", nw1, 5);
    chkw("t3_m0_rd", r2, 32'hC0FF_EE01);
    chkw("t3_m1_rd", r3, 32'h5EED_0002);

    // M1 back to back, req kept high across the ack
    step();
    s = cyc;
    do_txn(1, 1'b1, 7'h40, 32'h1111_0040, a0, r0, nw0);
    do_txn(1, 1'b1, 7'h7F, 32'h7F7F_7F7F, a1, r1, nw1);
    do_txn(1, 1'b0, 7'h7F, 32'h0, b0, r2, nw2);
    chkw("t4_first_cyc", a0, s + 2);
    chkw("t4_second_gap", a1 - a0, 3);
    chkw("t4_third_gap", b0 - a1, 3);
    chkw("t4_rd_7f", r2, 32'h7F7F_7F7F);

    // write withdrawn during ISSUE still completes
    step();
    s = cyc;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 7'h10;
    m0_wdata = 32'h1234_5678;
    step();
    m0_req = 1'b0;
    @(negedge clk);
    chkb("t5_issue_we", ram_we, 1'b1);
    @(negedge clk);
    chkb("t5_ack", m0_ack, 1'b1);
    step();
    s = cyc;
    do_txn(0, 1'b0, 7'h10, 32'h0, a0, r0, nw0);
    chkw("t5_rack_cyc", a0, s + 2);
    chkw("t5_rdata", r0, 32'h1234_5678);

    // asynchronous reset in the middle of a write's ISSUE cycle
    step();
    do_txn(0, 1'b1, 7'h22, 32'h1111_1111, a0, r0, nw0);
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 7'h22;
    m0_wdata = 32'hAAAA_5555;
    step();
    #1;
    chkb("t6_we_pre", ram_we, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chkb("t6_we_async", ram_we, 1'b0);
    chkb("t6_ack_async", m0_ack, 1'b0);
    m0_req = 1'b0;
    k = n_ack0;
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    chkw("t6_no_ack", n_ack0 - k, 0);
    s = cyc;
    do_txn(0, 1'b0, 7'h22, 32'h0, a0, r0, nw0);
    chkw("t6_rack_cyc", a0, s + 2);
    chkw("t6_rdata", r0, 32'h1111_1111);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
